// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader: word geometry and FSM state encoding.
package matrix_loader_pkg;

  localparam int WORD_W    = 32;
  localparam int MAT_WORDS = 9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_LAST = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/matrix_loader.sv
// Streams an N_WORDS matrix into data memory in row-major order over a valid/ready input.
// Accepted word appears on the write port one cycle later; in_ready is low outside LOAD.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int                N_WORDS   = MAT_WORDS,
  parameter logic [WORD_W-1:0] BASE_ADDR = 32'd0,
  parameter logic [WORD_W-1:0] ADDR_STEP = 32'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_w,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [3:0]        count
);

  localparam logic [3:0] LAST_COUNT = 4'(N_WORDS);

  state_t            state;
  logic [WORD_W-1:0] ptr;
  logic              xfer;

  assign xfer = in_valid && in_ready;

  // in_ready and busy are registered copies of the next-state decode so all outputs come from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      in_ready  <= 1'b0;
      mem_w     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      mem_w <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            count    <= '0;
            ptr      <= BASE_ADDR;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_w     <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            ptr       <= ptr + ADDR_STEP;
            count     <= count + 4'd1;
            if (count + 4'd1 == LAST_COUNT) begin
              state    <= ST_LAST;
              in_ready <= 1'b0;
            end
          end
        end
        ST_LAST: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboarded bench for matrix_loader: one instance at base 0, one at a wrapping base, same stimulus.
module tb_matrix_loader;
  import matrix_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;

  logic        in_ready_a, mem_w_a, busy_a, done_a;
  logic [31:0] mem_addr_a, mem_wdata_a;
  logic [3:0]  count_a;
  logic        in_ready_b, mem_w_b, busy_b, done_b;
  logic [31:0] mem_addr_b, mem_wdata_b;
  logic [3:0]  count_b;

  matrix_loader #(.N_WORDS(9), .BASE_ADDR(32'd0), .ADDR_STEP(32'd1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .mem_w(mem_w_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .busy(busy_a), .done(done_a), .count(count_a)
  );

  matrix_loader #(.N_WORDS(9), .BASE_ADDR(32'hFFFF_FFFE), .ADDR_STEP(32'd1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .mem_w(mem_w_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .busy(busy_b), .done(done_b), .count(count_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q_a[$];
  wr_t         q_b[$];
  logic [31:0] exp_addr_a, exp_addr_b;
  logic [31:0] last_addr_a = '0;
  logic [31:0] last_addr_b = '0;
  logic        in_load  = 1'b0;
  logic        acc_prev = 1'b0;

  // Write-port monitor: a write is due exactly one cycle after each bench-side acceptance.
  always @(negedge clk) begin
    logic acc;
    wr_t  w;
    if (!reset) begin
      check("mem_w_a", {31'd0, mem_w_a}, {31'd0, acc_prev});
      check("mem_w_b", {31'd0, mem_w_b}, {31'd0, acc_prev});
      if (mem_w_a && q_a.size() > 0) begin
        w = q_a.pop_front();
        check("addr_a", mem_addr_a, w.addr);
        check("data_a", mem_wdata_a, w.data);
        last_addr_a = mem_addr_a;
      end
      if (mem_w_b && q_b.size() > 0) begin
        w = q_b.pop_front();
        check("addr_b", mem_addr_b, w.addr);
        check("data_b", mem_wdata_b, w.data);
        last_addr_b = mem_addr_b;
      end
      acc = in_load && in_valid;
      if (acc) begin
        q_a.push_back('{addr: exp_addr_a, data: in_data});
        q_b.push_back('{addr: exp_addr_b, data: in_data});
        exp_addr_a = exp_addr_a + 32'd1;
        exp_addr_b = exp_addr_b + 32'd1;
      end
      acc_prev = acc;
    end else begin
      acc_prev = 1'b0;
    end
  end

  task automatic check_zero_outs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready_a | in_ready_b}, 32'd0);
    check({tag, "_mem_w"},    {31'd0, mem_w_a | mem_w_b}, 32'd0);
    check({tag, "_addr_a"},   mem_addr_a, 32'd0);
    check({tag, "_addr_b"},   mem_addr_b, 32'd0);
    check({tag, "_wdata"},    mem_wdata_a | mem_wdata_b, 32'd0);
    check({tag, "_busy"},     {31'd0, busy_a | busy_b}, 32'd0);
    check({tag, "_done"},     {31'd0, done_a | done_b}, 32'd0);
    check({tag, "_count"},    {28'd0, count_a | count_b}, 32'd0);
  endtask

  // gap=1 gives the valid pattern 1,0,0,1,...; abort_after>0 resets after that many words.
  task automatic run_load(input bit gap, input bit start_mid, input int abort_after);
    int n     = 0;
    int cyc   = 0;
    int limit = (abort_after > 0) ? abort_after : MAT_WORDS;
    @(posedge clk); #1;
    start      = 1'b1;
    exp_addr_a = 32'h0000_0000;
    exp_addr_b = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    start   = 1'b0;
    in_load = 1'b1;
    while (n < limit && cyc < 100) begin
      in_valid = !gap || (cyc % 3 == 0);
      in_data  = in_valid ? 32'(n + 1) : 32'hDEAD_0000 + 32'(cyc);
      start    = start_mid && (cyc == 2);
      @(negedge clk);
      check("in_ready_load", {31'd0, in_ready_a}, 32'd1);
      check("count_load_a", {28'd0, count_a}, 32'(n));
      check("count_load_b", {28'd0, count_b}, 32'(n));
      if (in_valid) n++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_load  = 1'b0;
    start    = 1'b0;
    if (cyc >= 100) check("load_timeout", 32'(n), 32'(limit));
    if (abort_after > 0) begin
      @(negedge clk); #1;
      reset = 1'b1;
      q_a.delete();
      q_b.delete();
      #1;
      check_zero_outs("abort");
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      @(negedge clk);
      check("last_in_ready", {31'd0, in_ready_a}, 32'd0);
      check("last_busy", {31'd0, busy_a}, 32'd1);
      check("last_done", {31'd0, done_a}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_a", {31'd0, done_a}, 32'd1);
      check("done_b", {31'd0, done_b}, 32'd1);
      check("done_busy", {31'd0, busy_a}, 32'd0);
      check("done_count_a", {28'd0, count_a}, 32'd9);
      check("done_count_b", {28'd0, count_b}, 32'd9);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", {31'd0, done_a}, 32'd0);
      check("idle_count_hold", {28'd0, count_a}, 32'd9);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not produced");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check_zero_outs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Valid in IDLE must not be accepted.
    in_valid = 1'b1;
    in_data  = 32'hBAD0_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    run_load(1'b0, 1'b0, 0);
    check("basic_last_addr_a", last_addr_a, 32'd8);
    check("wrap_last_addr_b", last_addr_b, 32'd6);

    run_load(1'b1, 1'b1, 0);
    run_load(1'b0, 1'b0, 4);
    run_load(1'b0, 1'b0, 0);
    check("post_abort_last_addr_a", last_addr_a, 32'd8);

    repeat (2) @(posedge clk);
    check("sb_drain_a", 32'(q_a.size()), 32'd0);
    check("sb_drain_b", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
